// File: rtl/wb_port_scheduler.sv
// Arbitrates the single RegFile write port between pipeline writeback (A) and a
// long-latency unit (B), tracks B destinations for decode hazards, and forces a slot when B starves.
//
//  state  | meaning
//  NORMAL | A has priority, B takes idle slots
//  FORCE  | B starved; stall_req asks the pipeline to leave the next slot free
module wb_port_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_we,
    input  logic [4:0]  a_adr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    input  logic [4:0]  b_adr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        hazard,
    output logic        stall_req,
    output logic        we_wb,
    output logic [4:0]  wadr,
    output logic [31:0] wb_data
);

    typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      busy;
    logic [31:0]      set_mask;
    logic [31:0]      clr_mask;
    logic             b_hs;
    logic             b_starved;

    // Port mux: A can never be back-pressured, so it always wins.
    always_comb begin
        we_wb   = 1'b0;
        wadr    = 5'd0;
        wb_data = 32'd0;
        b_ready = 1'b0;
        if (a_we) begin
            we_wb   = (a_adr != 5'd0);
            wadr    = a_adr;
            wb_data = a_data;
        end else if (b_valid) begin
            we_wb   = (b_adr != 5'd0);
            wadr    = b_adr;
            wb_data = b_data;
            b_ready = 1'b1;
        end
    end

    assign b_hs      = b_valid & b_ready;
    assign b_starved = b_valid & ~b_ready;

    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue_valid && issue_rd != 5'd0)
            set_mask[issue_rd] = 1'b1;
        if (b_hs)
            clr_mask[b_adr] = 1'b1;
    end

    // Set is applied after clear so a same-cycle reissue of the destination stays busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= 32'd0;
        else
            busy <= ((busy & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
    end

    assign hazard = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            state     <= NORMAL;
            stall_req <= 1'b0;
        end else begin
            if (!b_starved)
                wait_cnt <= '0;
            else if (wait_cnt != LIMIT)
                wait_cnt <= wait_cnt + 1'b1;

            case (state)
                NORMAL: begin
                    if (wait_cnt == LIMIT) begin
                        state     <= FORCE;
                        stall_req <= 1'b1;
                    end
                end
                FORCE: begin
                    if (b_hs || !b_valid) begin
                        state     <= NORMAL;
                        stall_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= NORMAL;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler: port mux, x0 handling, scoreboard,
// starvation forcing and asynchronous reset.
module tb_wb_port_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_we;
    logic [4:0]  a_adr;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_adr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        hazard;
    logic        stall_req;
    logic        we_wb;
    logic [4:0]  wadr;
    logic [31:0] wb_data;

    int checks   = 0;
    int failures = 0;

    wb_port_scheduler #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_we(a_we), .a_adr(a_adr), .a_data(a_data),
        .b_valid(b_valid), .b_adr(b_adr), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .hazard(hazard), .stall_req(stall_req),
        .we_wb(we_wb), .wadr(wadr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_we = 0; a_adr = 0; a_data = 0;
        b_valid = 0; b_adr = 0; b_data = 0;
        issue_valid = 0; issue_rd = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #12;
        check("rst_stall", stall_req, 0);
        check("rst_hazard", hazard, 0);
        check("rst_we", we_wb, 0);
        rst_n = 1;
        step();

        // A beats B, then B takes the freed slot
        a_we = 1; a_adr = 5; a_data = 32'h11;
        b_valid = 1; b_adr = 6; b_data = 32'h22;
        #1;
        check("t1_we_a", we_wb, 1);
        check("t1_wadr_a", wadr, 5);
        check("t1_data_a", wb_data, 32'h11);
        check("t1_bready_a", b_ready, 0);
        step();
        a_we = 0;
        #1;
        check("t1_we_b", we_wb, 1);
        check("t1_wadr_b", wadr, 6);
        check("t1_data_b", wb_data, 32'h22);
        check("t1_bready_b", b_ready, 1);
        step();
        b_valid = 0;
        #1;
        check("t1_idle_we", we_wb, 0);
        check("t1_idle_wadr", wadr, 0);
        check("t1_idle_data", wb_data, 0);

        // scoreboard set and clear
        issue_valid = 1; issue_rd = 7;
        step();
        issue_valid = 0; dec_rs2 = 7;
        #1;
        check("t2_haz_set", hazard, 1);
        b_valid = 1; b_adr = 7; b_data = 32'h77;
        #1;
        check("t2_haz_hold", hazard, 1);
        step();
        b_valid = 0;
        #1;
        check("t2_haz_clr", hazard, 0);
        dec_rs2 = 0;

        // starvation: stall_req appears after the fifth starved edge
        a_we = 1; a_adr = 3; a_data = 32'h33;
        b_valid = 1; b_adr = 4; b_data = 32'h44;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("t3_nostall_%0d", i), stall_req, 0);
        end
        step();
        check("t3_stall", stall_req, 1);
        step();
        check("t3_stall_violation", stall_req, 1);
        a_we = 0;
        #1;
        check("t3_bready", b_ready, 1);
        check("t3_wadr", wadr, 4);
        check("t3_data", wb_data, 32'h44);
        step();
        check("t3_release", stall_req, 0);

        // starvation released by B withdrawing
        a_we = 1;
        for (int i = 0; i < 5; i++) step();
        check("t3b_stall", stall_req, 1);
        b_valid = 0;
        step();
        check("t3b_release", stall_req, 0);
        a_we = 0;

        // x0 writes
        a_we = 1; a_adr = 0; a_data = 32'h55;
        #1;
        check("t4_a_x0_we", we_wb, 0);
        a_we = 0; b_valid = 1; b_adr = 0; b_data = 32'h66;
        #1;
        check("t4_b_x0_ready", b_ready, 1);
        check("t4_b_x0_we", we_wb, 0);
        step();
        b_valid = 0;

        // set wins over same-cycle clear
        issue_valid = 1; issue_rd = 9;
        b_valid = 1; b_adr = 9; b_data = 32'h99;
        step();
        issue_valid = 0; b_valid = 0; dec_rs1 = 9;
        #1;
        check("t5_set_wins", hazard, 1);
        dec_rs1 = 0; dec_rd = 9;
        #1;
        check("t5_rd_haz", hazard, 1);
        b_valid = 1; b_adr = 9;
        step();
        b_valid = 0;
        #1;
        check("t5_cleared", hazard, 0);
        dec_rd = 0;

        // issue to x0 never marks busy
        issue_valid = 1; issue_rd = 0;
        step();
        issue_valid = 0;
        #1;
        check("t5_x0_busy", hazard, 0);

        // async reset mid-operation
        issue_valid = 1; issue_rd = 3;
        step();
        issue_valid = 0; dec_rs1 = 3;
        #1;
        check("t6_haz_pre", hazard, 1);
        a_we = 1; a_adr = 3; b_valid = 1; b_adr = 4;
        for (int i = 0; i < 5; i++) step();
        check("t6_stall_pre", stall_req, 1);
        #2;
        rst_n = 0;
        #1;
        check("t6_rst_stall", stall_req, 0);
        check("t6_rst_haz", hazard, 0);
        check("t6_rst_wadr", wadr, 3);
        check("t6_rst_we", we_wb, 1);
        step();
        rst_n = 1;
        idle_inputs();
        dec_rs1 = 3;
        step();
        check("t6_post_haz", hazard, 0);
        check("t6_post_stall", stall_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
